// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction width, canonical NOP and the
// prefetch buffer entry layout.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Circular prefetch buffer: slots are allocated on grant, filled in order on
// response and consumed from the head; flush empties it in one cycle.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_en,
    input  logic [XLEN-1:0]         alloc_pc,
    input  logic                    fill_en,
    input  logic [XLEN-1:0]         fill_instr,
    input  logic                    pop_en,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  outstanding,
    output fetch_entry_t            head_entry
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   ONE_W = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_H = PTR_W'(1);

    // alloc/fill carry a wrap bit so their difference distinguishes 0 from DEPTH
    logic [PTR_W:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W:0]   fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        entries_d   = entries_q;
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
        end else begin
            if (alloc_en) begin
                entries_d[alloc_ptr_q[PTR_W-1:0]].pc     = alloc_pc;
                entries_d[alloc_ptr_q[PTR_W-1:0]].filled = 1'b0;
                alloc_ptr_d = alloc_ptr_q + ONE_W;
            end
            if (fill_en) begin
                entries_d[fill_ptr_q[PTR_W-1:0]].instr  = fill_instr;
                entries_d[fill_ptr_q[PTR_W-1:0]].filled = 1'b1;
                fill_ptr_d = fill_ptr_q + ONE_W;
            end
            if (pop_en) begin
                head_ptr_d = head_ptr_q + ONE_H;
            end
            case ({alloc_en, pop_en})
                2'b10:   count_d = count_q + ONE_W;
                2'b01:   count_d = count_q - ONE_W;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
        end
    end

    // pc/instr payload is never reset; only the filled flags are
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].filled <= 1'b0;
            end
        end
    end

    assign count       = count_q;
    assign outstanding = alloc_ptr_q - fill_ptr_q;
    assign head_entry  = entries_q[head_ptr_q];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, issues in-order imem requests,
// discards responses made stale by redirects and feeds the fetch/decode stage.
module fetch_prefetch
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] pcF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int DROP_W = $clog2(DEPTH) + 2;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DROP_W-1:0]     drop_count_q, drop_count_d;
    logic                  grant, resp_keep, pop;
    logic [CNT_W-1:0]      alloc_count, outstanding;
    fetch_entry_t          head;

    fetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (PCSrc),
        .alloc_en   (grant),
        .alloc_pc   (fetch_pc_q),
        .fill_en    (resp_keep),
        .fill_instr (imem_rdata),
        .pop_en     (pop),
        .count      (alloc_count),
        .outstanding(outstanding),
        .head_entry (head)
    );

    always_comb begin
        imem_req  = !rst && !PCSrc && (alloc_count < CNT_W'(DEPTH));
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        resp_keep = imem_rvalid && !PCSrc && (drop_count_q == '0);
        validF    = (alloc_count != '0) && head.filled;
        pop       = validF && !stall && !PCSrc;
        instrF    = validF ? head.instr : NOP_INSTR;
        pcF       = validF ? head.pc : '0;
        PCPlus4F  = validF ? head.pc + DATA_WIDTH'(4) : '0;

        fetch_pc_d = fetch_pc_q;
        if (PCSrc) begin
            fetch_pc_d = PCTarget;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        end

        // every unfilled slot becomes a stale response; one arriving now is already spent
        drop_count_d = drop_count_q;
        if (PCSrc) begin
            drop_count_d = drop_count_q + DROP_W'(outstanding) - DROP_W'(imem_rvalid);
        end else if (imem_rvalid && (drop_count_q != '0)) begin
            drop_count_d = drop_count_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            drop_count_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: queue-based model of the prefetch buffer
// plus a latency-programmable in-order memory, checked every cycle.
module tb_fetch_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] PCPlus4F;
    logic        validF;

    fetch_prefetch #(
        .DATA_WIDTH(32),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrF     (instrF),
        .pcF        (pcF),
        .PCPlus4F   (PCPlus4F),
        .validF     (validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus knobs
    logic        rst_v, pcsrc_v, stall_v, gnt_v;
    logic [31:0] tgt_v;
    int          lat;

    // memory: in-order pending responses
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    last_due;
    int    cyc;

    // behavioural model
    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ment_t;
    ment_t       mb[$];
    logic [31:0] m_pc;
    int          m_drop;

    // sampled DUT outputs of the latest cycle
    logic        s_req, s_valid, s_grant;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    int n_cmp;
    int n_bad;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic        rv;
        logic [31:0] rd;
        logic        e_req, e_valid;
        int          u, k, due;
        @(negedge clk);
        rst      = rst_v;
        PCSrc    = pcsrc_v;
        PCTarget = tgt_v;
        stall    = stall_v;
        imem_gnt = gnt_v;
        rv = 1'b0;
        rd = 32'h0;
        if (!rst_v && mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            rd = mword(mq[0].addr);
            void'(mq.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = validF;
        s_instr = instrF;
        s_pc    = pcF;
        s_pc4   = PCPlus4F;
        s_grant = imem_req && gnt_v;

        e_req   = !rst_v && !pcsrc_v && (mb.size() < DEPTH);
        e_valid = (mb.size() > 0) && mb[0].filled;
        check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (!rst_v) begin
            if (e_req) check("imem_addr", imem_addr, m_pc);
            check("validF", {31'b0, validF}, {31'b0, e_valid});
            check("instrF", instrF, e_valid ? mb[0].instr : NOP);
            check("pcF", pcF, e_valid ? mb[0].pc : 32'h0);
            check("PCPlus4F", PCPlus4F, e_valid ? mb[0].pc + 32'd4 : 32'h0);
        end

        // memory accepts what the DUT actually requested
        if (!rst_v && s_grant) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{imem_addr, due});
            last_due = due;
        end

        if (rst_v) begin
            mb.delete();
            mq.delete();
            m_pc     = 32'h0;
            m_drop   = 0;
            last_due = cyc;
        end else if (pcsrc_v) begin
            u = 0;
            foreach (mb[i]) if (!mb[i].filled) u++;
            m_drop = m_drop + u - (rv ? 1 : 0);
            mb.delete();
            m_pc = tgt_v;
        end else begin
            if (rv) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    k = -1;
                    foreach (mb[i]) if (!mb[i].filled && k < 0) k = i;
                    if (k >= 0) begin
                        mb[k].instr  = rd;
                        mb[k].filled = 1'b1;
                    end
                end
            end
            if (e_valid && !stall_v) void'(mb.pop_front());
            if (e_req && gnt_v) begin
                mb.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_v   = 1'b1;
        pcsrc_v = 1'b0;
        stall_v = 1'b0;
        gnt_v   = 1'b1;
        step();
        check("rst_req", {31'b0, s_req}, 32'h0);
        step();
        rst_v = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!s_valid && i < budget);
        if (!s_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no validF within %0d cycles", nm, budget);
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        pcsrc_v = 1'b1;
        tgt_v   = t;
        step();
        pcsrc_v = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr, np;
        bit got;
        n_cmp = 0; n_bad = 0; cyc = 0; last_due = -1;
        rst = 1'b1; PCSrc = 1'b0; PCTarget = '0; stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        rst_v = 1'b1; pcsrc_v = 1'b0; stall_v = 1'b0; gnt_v = 1'b1; tgt_v = '0;
        m_pc = 32'h0; m_drop = 0; lat = 1;

        // sequential fetch, latency 1
        do_reset();
        step();
        check("t1_addr0", s_addr, 32'h0);
        check("t1_valid0", {31'b0, s_valid}, 32'h0);
        check("t1_instr_nop", s_instr, NOP);
        check("t1_pc_zero", s_pc, 32'h0);
        check("t1_pc4_zero", s_pc4, 32'h0);
        step();
        check("t1_addr1", s_addr, 32'h4);
        step();
        check("t1_addr2", s_addr, 32'h8);
        check("t1_first_valid", {31'b0, s_valid}, 32'h1);
        check("t1_first_pc", s_pc, 32'h0);
        check("t1_first_pc4", s_pc4, 32'h4);
        check("t1_first_instr", s_instr, mword(32'h0));
        step();
        check("t1_second_pc", s_pc, 32'h4);
        run(4);

        // stall fills the buffer, release drains it in order
        do_reset();
        stall_v = 1'b1;
        ngr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_grant) ngr++;
        end
        check("t2_grants", ngr, 4);
        check("t2_req_full", {31'b0, s_req}, 32'h0);
        stall_v = 1'b0;
        np = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && (np < 4 || !got); i++) begin
            step();
            if (s_valid && np < 4) begin
                check("t2_pop_pc", s_pc, 32'(np * 4));
                np++;
            end
            if (s_grant && !got) begin
                check("t2_resume_addr", s_addr, 32'h10);
                got = 1'b1;
            end
        end
        check("t2_pop_count", np, 4);
        check("t2_resumed", {31'b0, got}, 32'h1);

        // redirect with two responses outstanding, latency 3
        do_reset();
        lat = 3;
        run(2);
        redirect(32'h100);
        check("t3_req_in_redirect", {31'b0, s_req}, 32'h0);
        step();
        check("t3_addr_target", s_addr, 32'h100);
        wait_valid("t3_first_valid", 12);
        check("t3_first_pc", s_pc, 32'h100);
        check("t3_first_instr", s_instr, mword(32'h100));

        // redirect coinciding with an old response, latency 2
        do_reset();
        lat = 2;
        run(3);
        redirect(32'h40);
        check("t4_valid_in_redirect", {31'b0, s_valid}, 32'h1);
        check("t4_pc_in_redirect", s_pc, 32'h0);
        wait_valid("t4_first_valid", 12);
        check("t4_first_pc", s_pc, 32'h40);
        check("t4_first_instr", s_instr, mword(32'h40));

        // two redirects one cycle apart, latency 4
        do_reset();
        lat = 4;
        run(2);
        redirect(32'h200);
        step();
        redirect(32'h300);
        wait_valid("t5_first_valid", 16);
        check("t5_first_pc", s_pc, 32'h300);
        check("t5_first_instr", s_instr, mword(32'h300));
        run(3);
        redirect(32'h500);
        redirect(32'h600);
        wait_valid("t5b_first_valid", 16);
        check("t5b_first_pc", s_pc, 32'h600);

        // irregular grant/stall pattern, unaligned and wrapping targets
        do_reset();
        lat = 2;
        for (int i = 0; i < 30; i++) begin
            gnt_v   = (i % 3) != 0;
            stall_v = (i % 4) == 1;
            step();
        end
        gnt_v = 1'b1;
        stall_v = 1'b0;
        redirect(32'h0000_0203);
        wait_valid("t6_unaligned_valid", 12);
        check("t6_unaligned_pc", s_pc, 32'h0000_0203);
        check("t6_unaligned_pc4", s_pc4, 32'h0000_0207);
        redirect(32'hFFFF_FFFC);
        wait_valid("t6_wrap_valid", 12);
        check("t6_wrap_pc", s_pc, 32'hFFFF_FFFC);
        check("t6_wrap_pc4", s_pc4, 32'h0);
        check("t6_wrap_instr", s_instr, mword(32'hFFFF_FFFC));
        wait_valid("t6_after_wrap_valid", 12);
        check("t6_after_wrap_pc", s_pc, 32'h0);

        // reset with a full, stalled buffer
        do_reset();
        lat = 1;
        stall_v = 1'b1;
        run(8);
        check("t7_full_valid", {31'b0, s_valid}, 32'h1);
        check("t7_full_req", {31'b0, s_req}, 32'h0);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        step();
        check("t7_valid_after_rst", {31'b0, s_valid}, 32'h0);
        check("t7_instr_after_rst", s_instr, NOP);
        check("t7_pc_after_rst", s_pc, 32'h0);
        check("t7_pc4_after_rst", s_pc4, 32'h0);
        check("t7_addr_after_rst", s_addr, 32'h0);
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
